if_id_pipe_reg: RTL

- Parametrised successor of the fetch/decode pipeline register.
- Carries LANES fetch lanes (pc, pc+4, instruction, per-lane valid) from the IF stage to the ID stage.
- Uses a valid/ready handshake with an optional two-entry skid buffer, so downstream stalls do not combinationally reach the fetch unit.
- Adds synchronous flush with NOP injection, asynchronous reset, and saturating stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/sat_counter.sv | 23 ++
 rtl/if_id_pipe_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register.
//   NOP_INST : default instruction shown on idle or flushed lanes (addi x0,x0,0)
//   pipe_state_e : occupancy of the main/skid register pair
//   lane_lsb : bit offset of a lane inside a lane-packed bus (lane 0 in LSBs)
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } pipe_state_e;

  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned xlen);
    return lane * xlen;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance monitoring.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : increment request for this cycle
//   cnt   : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF -> ID pipeline register carrying LANES fetch lanes per bundle.
// Valid/ready handshake on both sides; with SKID=1 a second (skid) entry
// lets in_ready be a register so ID stalls never reach fetch combinationally.
// Synchronous flush empties the stage and drops any same-cycle input.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : IF-side handshake
//   in_lane_vld, in_pc, in_pc4, in_inst : incoming bundle, lane 0 in LSBs
//   flush                 : kill held and incoming bundles
//   out_valid / out_ready : ID-side handshake
//   out_lane_vld, out_pc, out_pc4, out_inst : held bundle (NOP/zero when idle)
//   perf_stall_cnt        : saturating count of out_valid & !out_ready cycles
//   perf_flush_cnt        : saturating count of flushes that killed something
module if_id_pipe_reg #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      LANES    = 1,
  parameter int unsigned      SKID     = 1,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(pipe_pkg::NOP_INST),
  parameter int unsigned      PERF_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_vld,
  input  logic [LANES*XLEN-1:0] in_pc,
  input  logic [LANES*XLEN-1:0] in_pc4,
  input  logic [LANES*XLEN-1:0] in_inst,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [LANES*XLEN-1:0] out_pc,
  output logic [LANES*XLEN-1:0] out_pc4,
  output logic [LANES*XLEN-1:0] out_inst,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic [PERF_W-1:0]     perf_flush_cnt
);

  import pipe_pkg::*;

  pipe_state_e           state;
  logic                  in_ready_q;
  logic                  in_xfer;
  logic                  out_xfer;

  logic [LANES-1:0]      m_lane, s_lane;
  logic [LANES*XLEN-1:0] m_pc,   s_pc;
  logic [LANES*XLEN-1:0] m_pc4,  s_pc4;
  logic [LANES*XLEN-1:0] m_inst, s_inst;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_lane     <= '0;
      m_pc       <= '0;
      m_pc4      <= '0;
      m_inst     <= '0;
      s_lane     <= '0;
      s_pc       <= '0;
      s_pc4      <= '0;
      s_inst     <= '0;
    end else if (flush) begin
      // Payload is left stale; out_valid=0 masks it.
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else if (SKID != 0) begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_lane <= in_lane_vld;
            m_pc   <= in_pc;
            m_pc4  <= in_pc4;
            m_inst <= in_inst;
            state  <= ST_FULL1;
          end
        end
        ST_FULL1: begin
          if (in_xfer && out_xfer) begin
            m_lane <= in_lane_vld;
            m_pc   <= in_pc;
            m_pc4  <= in_pc4;
            m_inst <= in_inst;
          end else if (in_xfer) begin
            // ID stalled: park the new bundle and stop accepting next cycle.
            s_lane     <= in_lane_vld;
            s_pc       <= in_pc;
            s_pc4      <= in_pc4;
            s_inst     <= in_inst;
            state      <= ST_FULL2;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL2: begin
          if (out_xfer) begin
            m_lane     <= s_lane;
            m_pc       <= s_pc;
            m_pc4      <= s_pc4;
            m_inst     <= s_inst;
            state      <= ST_FULL1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end else begin
      if (in_xfer) begin
        m_lane <= in_lane_vld;
        m_pc   <= in_pc;
        m_pc4  <= in_pc4;
        m_inst <= in_inst;
        state  <= ST_FULL1;
      end else if (out_xfer) begin
        state <= ST_EMPTY;
      end
    end
  end

  always_comb begin
    out_lane_vld = out_valid ? m_lane : '0;
    out_pc       = out_valid ? m_pc   : '0;
    out_pc4      = out_valid ? m_pc4  : '0;
    out_inst     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_inst[lane_lsb(i, XLEN) +: XLEN] =
        out_valid ? m_inst[lane_lsb(i, XLEN) +: XLEN] : NOP_INST;
    end
  end

  logic stall_en;
  logic flush_en;

  assign stall_en = out_valid && !out_ready;
  // A non-empty stage means M (and possibly S) holds a live bundle.
  assign flush_en = flush && (out_valid || in_valid);

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .cnt   (perf_stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .cnt   (perf_flush_cnt)
  );

endmodule
